// File: rtl/vram_pkg.sv
// Shared VRAM geometry, pixel type and arbiter state encoding for the strip
// buffer write path.
package vram_pkg;
   localparam int VRAM_AW     = 19;
   localparam int VRAM_DW     = 12;
   localparam int STRIP_LINES = 32;
   localparam int H_ACTIVE    = 640;
   localparam int STRIP_DEPTH = STRIP_LINES * H_ACTIVE;

   typedef logic [VRAM_DW-1:0] pixel_t;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      SWAP
   } arb_state_t;
endpackage

// File: rtl/vram_write_arbiter_rr_pick.sv
// Round-robin picker: first asserted valid bit at or after ptr_i, wrapping
// modulo NREQ.
module rr_pick #(
   parameter int NREQ = 3,
   localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] valid_i,
   input  logic [IW-1:0]   ptr_i,
   output logic            found_o,
   output logic [IW-1:0]   idx_o
);
   always_comb begin
      int j;
      found_o = 1'b0;
      idx_o   = '0;
      j       = 0;
      // Walk from the farthest offset back so the nearest valid index wins.
      for (int k = NREQ - 1; k >= 0; k--) begin
         j = (int'(ptr_i) + k) % NREQ;
         if (valid_i[j]) begin
            found_o = 1'b1;
            idx_o   = IW'(j);
         end
      end
   end
endmodule

// File: rtl/vram_write_arbiter.sv
// Round-robin, burst-locked arbiter for the single VRAM write port, gated by
// the scan write window, with burst-safe double-buffer bank swapping.
module vram_write_arbiter
   import vram_pkg::*;
#(
   parameter int NREQ     = 3,
   parameter int AW       = VRAM_AW,
   parameter int DW       = VRAM_DW,
   parameter int MAXBURST = 640,
   localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1,
   localparam int CW      = $clog2(MAXBURST + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               win_en,
   input  logic               swap,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ-1:0]    req_last,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    req_ready,
   output logic               wr_en,
   output logic [AW-1:0]      wr_addr,
   output logic [DW-1:0]      wr_data,
   output logic [IW-1:0]      grant_id,
   output logic               busy,
   output logic               bank_sel,
   output logic               swap_ack
);
   arb_state_t    state_q;
   logic [IW-1:0] rr_ptr_q;
   logic [IW-1:0] grant_id_q;
   logic [CW-1:0] beat_cnt_q;
   logic          swap_pend_q;
   logic          wr_en_q;
   logic [AW-1:0] wr_addr_q;
   logic [DW-1:0] wr_data_q;
   logic          bank_sel_q;
   logic          swap_ack_q;

   logic          pick_found;
   logic [IW-1:0] pick_idx;
   logic          g_valid;
   logic          g_last;
   logic          xfer;
   logic          cnt_full;
   logic          release_g;
   logic [IW-1:0] next_ptr_d;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .valid_i (req_valid),
      .ptr_i   (rr_ptr_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   assign g_valid   = req_valid[grant_id_q];
   assign g_last    = req_last[grant_id_q];
   assign xfer      = (state_q == GRANT) && win_en && g_valid;
   assign cnt_full  = (beat_cnt_q + CW'(1)) == CW'(MAXBURST);
   // A requester that goes idle inside an open window gives up the port.
   assign release_g = (state_q == GRANT) &&
                      ((xfer && (g_last || cnt_full)) || (win_en && !g_valid));
   assign next_ptr_d = (grant_id_q == IW'(NREQ - 1)) ? '0 : grant_id_q + IW'(1);

   always_comb begin
      req_ready = '0;
      if (state_q == GRANT) req_ready[grant_id_q] = win_en;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         grant_id_q  <= '0;
         beat_cnt_q  <= '0;
         swap_pend_q <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         bank_sel_q  <= 1'b0;
         swap_ack_q  <= 1'b0;
      end else begin
         wr_en_q     <= xfer;
         swap_ack_q  <= 1'b0;
         swap_pend_q <= swap_pend_q | swap;
         if (xfer) begin
            wr_addr_q  <= req_addr[grant_id_q*AW +: AW];
            wr_data_q  <= req_data[grant_id_q*DW +: DW];
            beat_cnt_q <= beat_cnt_q + CW'(1);
         end
         case (state_q)
            IDLE: begin
               // A pending swap is served before any new grant.
               if (swap_pend_q) begin
                  state_q    <= SWAP;
                  bank_sel_q <= ~bank_sel_q;
                  swap_ack_q <= 1'b1;
               end else if (pick_found) begin
                  grant_id_q <= pick_idx;
                  beat_cnt_q <= '0;
                  state_q    <= GRANT;
               end
            end
            GRANT: begin
               if (release_g) begin
                  state_q  <= IDLE;
                  rr_ptr_q <= next_ptr_d;
               end
            end
            SWAP: begin
               swap_pend_q <= 1'b0;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign wr_en    = wr_en_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign grant_id = grant_id_q;
   assign busy     = (state_q == GRANT);
   assign bank_sel = bank_sel_q;
   assign swap_ack = swap_ack_q;
endmodule

// File: tb/tb_vram_write_arbiter.sv
// Bench for vram_write_arbiter: requester model plus a write scoreboard that
// expects every accepted beat on the VRAM port exactly one cycle later.
module tb_vram_write_arbiter;
   localparam int NREQ = 3;
   localparam int AW   = 19;
   localparam int DW   = 12;
   localparam int IW   = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               reset, win_en, swap;
   logic [NREQ-1:0]    req_valid, req_last;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_data;

   logic [NREQ-1:0] rdy_a, rdy_b, m_ready;
   logic            wen_a, wen_b, m_wr_en;
   logic [AW-1:0]   wad_a, wad_b, m_wr_addr;
   logic [DW-1:0]   wda_a, wda_b, m_wr_data;
   logic [IW-1:0]   gid_a, gid_b, m_grant_id;
   logic            bsy_a, bsy_b, m_busy;
   logic            bks_a, bks_b, m_bank_sel;
   logic            ack_a, ack_b, m_swap_ack;

   bit sel4 = 1'b0;

   vram_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAXBURST(640)) dut (
      .clk(clk), .reset(reset), .win_en(win_en), .swap(swap),
      .req_valid(req_valid), .req_last(req_last), .req_addr(req_addr), .req_data(req_data),
      .req_ready(rdy_a), .wr_en(wen_a), .wr_addr(wad_a), .wr_data(wda_a),
      .grant_id(gid_a), .busy(bsy_a), .bank_sel(bks_a), .swap_ack(ack_a)
   );

   vram_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAXBURST(4)) dut4 (
      .clk(clk), .reset(reset), .win_en(win_en), .swap(swap),
      .req_valid(req_valid), .req_last(req_last), .req_addr(req_addr), .req_data(req_data),
      .req_ready(rdy_b), .wr_en(wen_b), .wr_addr(wad_b), .wr_data(wda_b),
      .grant_id(gid_b), .busy(bsy_b), .bank_sel(bks_b), .swap_ack(ack_b)
   );

   assign m_ready    = sel4 ? rdy_b : rdy_a;
   assign m_wr_en    = sel4 ? wen_b : wen_a;
   assign m_wr_addr  = sel4 ? wad_b : wad_a;
   assign m_wr_data  = sel4 ? wda_b : wda_a;
   assign m_grant_id = sel4 ? gid_b : gid_a;
   assign m_busy     = sel4 ? bsy_b : bsy_a;
   assign m_bank_sel = sel4 ? bks_b : bks_a;
   assign m_swap_ack = sel4 ? ack_b : ack_a;

   int vectors = 0;
   int errors  = 0;
   int nwr     = 0;
   int hs_done = 0;

   int               rem[NREQ];
   bit               endless[NREQ];
   logic [AW-1:0]    a_n[NREQ];
   logic [DW-1:0]    d_n[NREQ];
   logic [AW+DW-1:0] sb_q[$];
   int               hs_id[$];
   int               hs_cyc[$];

   // Handshake recorder: expected write is pushed when the beat is accepted.
   always @(posedge clk) begin
      if (reset === 1'b1) begin
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && m_ready[i] === 1'b1) begin
               sb_q.push_back({req_addr[i*AW +: AW], req_data[i*DW +: DW]});
               hs_id.push_back(i);
               hs_cyc.push_back(int'($time / 10));
            end
         end
      end
   end

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]            = endless[i] || (rem[i] > 0);
         req_last[i]             = !endless[i] && (rem[i] == 1);
         req_addr[i*AW +: AW]    = a_n[i];
         req_data[i*DW +: DW]    = d_n[i];
      end
   endtask

   task automatic step();
      logic [AW+DW-1:0] exp;
      @(negedge clk);
      if (m_wr_en === 1'b1) begin
         vectors++;
         nwr++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL wr_spurious: wr_en=1 addr=%h data=%h, expected no write", m_wr_addr, m_wr_data);
         end else begin
            exp = sb_q.pop_front();
            if ({m_wr_addr, m_wr_data} !== exp) begin
               errors++;
               $display("FAIL wr_beat: got addr=%h data=%h, expected addr=%h data=%h",
                        m_wr_addr, m_wr_data, exp[AW+DW-1:DW], exp[DW-1:0]);
            end
         end
      end else if (sb_q.size() != 0) begin
         vectors++;
         errors++;
         $display("FAIL wr_missing: wr_en=%b, expected write addr=%h one cycle after accept",
                  m_wr_en, sb_q[0][AW+DW-1:DW]);
         sb_q.delete();
      end
      if ($countones(m_ready) > 1) begin
         vectors++;
         errors++;
         $display("FAIL ready_onehot: req_ready=%b, expected at most one bit", m_ready);
      end
      while (hs_done < hs_id.size()) begin
         if (!endless[hs_id[hs_done]] && rem[hs_id[hs_done]] > 0) rem[hs_id[hs_done]]--;
         a_n[hs_id[hs_done]]++;
         d_n[hs_id[hs_done]]++;
         hs_done++;
      end
      drive();
   endtask

   task automatic do_reset(input int n);
      reset  = 1'b0;
      win_en = 1'b1;
      swap   = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         rem[i] = 0; endless[i] = 1'b0; a_n[i] = '0; d_n[i] = '0;
      end
      drive();
      hs_id.delete(); hs_cyc.delete(); sb_q.delete(); hs_done = 0;
      repeat (n) step();
      reset = 1'b1;
   endtask

   task automatic wait_hs(input int n, input int budget, input string name);
      int k = 0;
      while (hs_id.size() < n && k < budget) begin
         step();
         k++;
      end
      vectors++;
      if (hs_id.size() < n) begin
         errors++;
         $display("FAIL %s_timeout: %0d handshakes, expected %0d", name, hs_id.size(), n);
      end
   endtask

   task automatic test_reset();
      do_reset(0);
      reset = 1'b0;
      for (int i = 0; i < NREQ; i++) endless[i] = 1'b1;
      drive();
      for (int k = 0; k < 3; k++) begin
         step();
         vectors++;
         if ({m_wr_en, m_wr_addr, m_wr_data, m_ready, m_busy, m_bank_sel, m_swap_ack, m_grant_id} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: wr_en=%b addr=%h data=%h ready=%b busy=%b bank=%b ack=%b gid=%0d, expected all 0",
                     m_wr_en, m_wr_addr, m_wr_data, m_ready, m_busy, m_bank_sel, m_swap_ack, m_grant_id);
         end
      end
      reset = 1'b1;
      step();
      vectors++;
      if ({m_busy, m_grant_id} !== {1'b1, 2'd0}) begin
         errors++;
         $display("FAIL reset_first_grant: busy=%b gid=%0d, expected busy=1 gid=0", m_busy, m_grant_id);
      end
   endtask

   task automatic test_single_burst();
      int first = -1;
      int last  = -1;
      do_reset(2);
      rem[0] = 4; a_n[0] = 19'd100; d_n[0] = 12'hF00;
      drive();
      nwr = 0;
      for (int k = 0; k < 12; k++) begin
         step();
         if (m_wr_en === 1'b1) begin
            if (first < 0) first = k;
            last = k;
         end
      end
      vectors++;
      if (nwr != 4 || last - first != 3) begin
         errors++;
         $display("FAIL single_writes: %0d writes spanning %0d cycles, expected 4 consecutive", nwr, last - first + 1);
      end
      vectors++;
      if ({m_busy, m_grant_id} !== {1'b0, 2'd0}) begin
         errors++;
         $display("FAIL single_idle: busy=%b gid=%0d, expected busy=0 gid=0", m_busy, m_grant_id);
      end
   endtask

   task automatic test_fairness();
      int bad = 0;
      sel4 = 1'b1;
      do_reset(2);
      for (int i = 0; i < NREQ; i++) begin
         endless[i] = 1'b1; a_n[i] = AW'(1000 * (i + 1)); d_n[i] = DW'(256 * (i + 1));
      end
      drive();
      repeat (24) step();
      for (int i = 0; i < NREQ; i++) endless[i] = 1'b0;
      drive();
      repeat (4) step();
      vectors++;
      if (hs_id.size() < 16) begin
         errors++;
         $display("FAIL fair_count: %0d beats, expected at least 16", hs_id.size());
      end else begin
         for (int j = 0; j < 16; j++) begin
            if (hs_id[j] != (j / 4) % 3) bad++;
            if (j > 0 && hs_cyc[j] - hs_cyc[j-1] != ((j % 4 == 0) ? 2 : 1)) bad++;
         end
         if (bad != 0) begin
            errors++;
            $display("FAIL fair_order: %0d beats off order 0,1,2,0 x4 with one idle gap (ids %0d %0d %0d %0d)",
                     bad, hs_id[0], hs_id[4], hs_id[8], hs_id[12]);
         end
      end
      sel4 = 1'b0;
   endtask

   task automatic test_window();
      do_reset(2);
      rem[0] = 8; a_n[0] = 19'd200; d_n[0] = 12'h100;
      drive();
      nwr = 0;
      wait_hs(2, 10, "win_pre");
      win_en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         vectors++;
         if ({m_ready, m_busy, m_wr_en, m_grant_id} !== {3'b000, 1'b1, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL win_gated: ready=%b busy=%b wr_en=%b gid=%0d, expected 000/1/0/0",
                     m_ready, m_busy, m_wr_en, m_grant_id);
         end
      end
      vectors++;
      if (hs_id.size() != 2) begin
         errors++;
         $display("FAIL win_frozen: %0d beats, expected 2 while window closed", hs_id.size());
      end
      win_en = 1'b1;
      wait_hs(8, 20, "win_post");
      step(); step();
      vectors++;
      if (nwr != 8 || m_busy !== 1'b0) begin
         errors++;
         $display("FAIL win_total: %0d writes busy=%b, expected 8 writes busy=0", nwr, m_busy);
      end
   endtask

   task automatic test_swap_during_burst();
      int acks = 0;
      int ack_edge = -1;
      logic ack_busy = 1'bx;
      do_reset(2);
      rem[0] = 6; a_n[0] = 19'd300; d_n[0] = 12'h200;
      rem[1] = 3; a_n[1] = 19'd400; d_n[1] = 12'h300;
      drive();
      wait_hs(2, 10, "swap_b2");
      swap = 1'b1; step(); swap = 1'b0;
      wait_hs(4, 10, "swap_b4");
      swap = 1'b1; step(); swap = 1'b0;
      wait_hs(6, 10, "swap_b6");
      for (int k = 0; k < 20 && hs_id.size() < 7; k++) begin
         step();
         if (m_swap_ack === 1'b1) begin
            acks++;
            ack_edge = int'($time / 10) - 1;
            ack_busy = m_busy;
         end
      end
      wait_hs(9, 20, "swap_req1");
      repeat (3) step();
      vectors++;
      if (acks != 1 || m_bank_sel !== 1'b1 || ack_busy !== 1'b0) begin
         errors++;
         $display("FAIL swap_ack: %0d acks bank_sel=%b busy_at_ack=%b, expected 1 ack bank_sel=1 busy=0",
                  acks, m_bank_sel, ack_busy);
      end
      vectors++;
      if (hs_id.size() < 9 || hs_id[0] != 0 || hs_id[5] != 0 || hs_id[6] != 1 || hs_id[8] != 1) begin
         errors++;
         $display("FAIL swap_order: %0d beats, expected req0 x6 then req1 x3", hs_id.size());
      end else begin
         vectors++;
         if (ack_edge != hs_cyc[5] + 1 || hs_cyc[6] != hs_cyc[5] + 4) begin
            errors++;
            $display("FAIL swap_timing: ack at +%0d, req1 at +%0d after last req0 beat, expected +1 and +4",
                     ack_edge - hs_cyc[5], hs_cyc[6] - hs_cyc[5]);
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      do_reset(2);
      swap = 1'b1; step(); swap = 1'b0;
      repeat (3) step();
      vectors++;
      if (m_bank_sel !== 1'b1) begin
         errors++;
         $display("FAIL mid_preswap: bank_sel=%b, expected 1", m_bank_sel);
      end
      rem[1] = 2; a_n[1] = 19'd600; d_n[1] = 12'h0A0;
      drive();
      wait_hs(2, 10, "mid_req1");
      repeat (3) step();
      rem[0] = 6; a_n[0] = 19'd700; d_n[0] = 12'h0B0;
      drive();
      wait_hs(4, 10, "mid_b2");
      reset = 1'b0;
      step();
      vectors++;
      if ({m_wr_en, m_busy, m_bank_sel, m_ready} !== '0) begin
         errors++;
         $display("FAIL mid_reset: wr_en=%b busy=%b bank_sel=%b ready=%b, expected all 0",
                  m_wr_en, m_busy, m_bank_sel, m_ready);
      end
      reset = 1'b1;
      rem[0] = 2; a_n[0] = 19'd800; d_n[0] = 12'h0C0;
      rem[1] = 1; rem[2] = 1; a_n[2] = 19'd900; d_n[2] = 12'h0D0;
      drive();
      wait_hs(5, 10, "mid_restart");
      vectors++;
      if (hs_id.size() < 5 || hs_id[4] != 0) begin
         errors++;
         $display("FAIL mid_restart: first grant after reset is req %0d, expected 0",
                  (hs_id.size() < 5) ? -1 : hs_id[4]);
      end
      repeat (8) step();
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_fairness();
      test_window();
      test_swap_during_burst();
      test_reset_mid_burst();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
